sample_player: RTL and testbench
================================

// Module: sample_player
// PURPOSE
//  Streams 16-bit audio samples out of the cellular-RAM controller at a fixed sample rate.
//  Issues word reads through the RAM controller's request/ready/valid port and buffers them in a small FIFO.
//  Emits one sample per sample tick to the downstream PWM/DAC stage.
//  Sits directly downstream of the RAM controller and consumes its data_read stream.
// PARAMETERS
//  CLK_DIV     2083  clocks per sample tick (100 MHz / 48 kHz); valid range >= 4
//  FIFO_DEPTH  8     sample buffer entries; power of 2, >= 2
//  ADDR_W      26    RAM word-address width (matches MemAdr[26:1])
//  DATA_W      16    sample / RAM word width
//  LEN_W       24    sample-count width
// PORTS
//  clk           in   1       system clock
//  rst           in   1       asynchronous, active-low reset (asserted when 0)
//  start         in   1       1-cycle pulse; begin playback (honoured only in IDLE)
//  stop          in   1       1-cycle pulse; abort playback
//  loop_en       in   1       1 = restart at base_addr after the last sample
//  base_addr     in   ADDR_W  first word address; latched on an accepted start
//  length        in   LEN_W   number of samples; latched on an accepted start
//  rd_req        out  1       read request to the RAM controller
//  rd_addr       out  ADDR_W  read word address
//  rd_ready      in   1       controller accepts the request (rd_req && rd_ready)
//  rd_valid      in   1       1-cycle pulse; rd_data is valid
//  rd_data       in   DATA_W  read word
//  sample_out    out  DATA_W  current sample; held between ticks
//  sample_strobe out  1       1-cycle pulse when sample_out updates
//  busy          out  1       high in RUN or DRAIN
//  done          out  1       1-cycle pulse at the end of non-loop playback
//  underrun      out  1       sticky; set on a tick with an empty FIFO; cleared by an accepted start
// BEHAVIOUR
//  Reset (rst==0): all outputs 0; FSM=IDLE; FIFO empty; all counters 0.
//  FSM states: IDLE, RUN, DRAIN.
//   IDLE->RUN: start==1 and length!=0. Latch base/length/loop_en; fetch addr=base; issued=played=0; tick ctr=0.
//   start with length==0 is ignored. start is ignored in RUN and DRAIN.
//   RUN->DRAIN: stop, or the last sample played with loop_en==0 (done pulses that cycle).
//   DRAIN->IDLE: when no read is outstanding (wait for rd_valid, then discard the data). FIFO is flushed on entry.
//   stop and start in the same cycle: stop wins.
//  Fetcher (RUN only):
//   Assert rd_req when issued<length and (fifo_count + outstanding) < FIFO_DEPTH.
//   At most 1 read is outstanding. rd_req/rd_addr stay stable until accepted.
//   On accept: addr+1 (mod 2^ADDR_W), issued+1.
//   In loop mode, when issued reaches length: addr=base and issued=0.
//   rd_valid in RUN pushes rd_data into the FIFO. rd_valid in IDLE or DRAIN is dropped.
//  Tick: counter counts 0..CLK_DIV-1 while in RUN and ticks at CLK_DIV-1; it is held at 0 otherwise.
//  On tick:
//   FIFO non-empty: pop; sample_out <= word (same cycle the strobe is registered); played+1.
//   FIFO empty: underrun<=1; no strobe; sample_out held; played unchanged.
//   Last sample (played reaches length): loop -> played=0; else -> done, DRAIN.
//  Push and pop in the same cycle: both occur, count unchanged. The FIFO never overflows (fetch gating).
//  Latency: first strobe at the first tick (CLK_DIV cycles after start); data must arrive before then.
//  sample_out keeps its last value after stop or done until the next strobe or reset.
// STRUCTURE
//  Shared include synth_defs.vh: FSM state encodings, ADDR_W/DATA_W defaults, CLK_DIV_48K constant.
//  Sub-module: sync_fifo (DATA_W x FIFO_DEPTH, push/pop/flush, count/empty/full).
//  All other logic (FSM, fetcher, tick divider) stays in sample_player.
// TESTING (CLK_DIV=8, FIFO_DEPTH=4, controller model with 3-cycle read latency)
//  1 Reset mid-RUN (rst=0 for 1 cycle) -> all outputs 0, FSM IDLE; next start plays normally.
//  2 RAM[0x100..0x104]=1..5, base=0x100, length=5, loop=0
//    -> strobes every 8 clk with 1,2,3,4,5; done once; busy falls; rd_addr never exceeds 0x104.
//  3 Same setup with loop=1, run 12 ticks -> 1..5,1..5,1,2; done never asserted; underrun=0.
//  4 Controller holds rd_ready=0 for 40 cycles -> underrun=1 and no strobes;
//    on release playback resumes at sample 1 and sample_out holds 0 until then.
//  5 stop issued one cycle after a read is accepted -> DRAIN until rd_valid, that data is discarded,
//    then IDLE; FIFO empty.
//  6 start with length=0 -> stays IDLE, busy=0. start+stop in the same cycle -> stays IDLE.
//    base=0x3FFFFFF, length=2 -> reads addr 0x3FFFFFF then 0x0000000.

Source files
------------

// File: rtl/sample_player_pkg.sv
// Shared constants for the sample player: FSM encodings and default widths/rates.
// No logic; imported by the player top.
package sample_player_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int ADDR_W_DEF  = 26;
    localparam int DATA_W_DEF  = 16;
    localparam int LEN_W_DEF   = 24;
    localparam int CLK_DIV_48K = 2083;   // 100 MHz / 48 kHz

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, first-word fall-through head; 1-cycle push-to-visible latency.
// Push while full is dropped unless a pop happens in the same cycle; flush empties it at once.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sample_player.sv
// Streams RAM words out as audio samples, one per CLK_DIV tick; first strobe CLK_DIV cycles after start.
// Holds rd_req/rd_addr until the controller accepts; at most one read in flight, fetch gated by FIFO room.
module sample_player
    import sample_player_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_48K,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LEN_W      = LEN_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              loop_en_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  length_i,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic              rd_ready_i,
    input  logic              rd_valid_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] sample_out_o,
    output logic              sample_strobe_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              underrun_o
);
    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d, issued_q, issued_d, played_q, played_d;
    logic              loop_q, loop_d, outst_q, outst_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              strobe_q, strobe_d, done_q, done_d, underrun_q, underrun_d;

    logic              fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
    logic [DATA_W-1:0] fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              accept, tick;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .din_i   (rd_data_i),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Only counts words already buffered plus the one in flight, so a granted read always has a slot.
    assign rd_req_o  = (state_q == ST_RUN) && !outst_q && (issued_q < len_q) && !fifo_full
                       && ((fifo_count + CW'(outst_q)) < DEPTH_CNT);
    assign rd_addr_o = addr_q;
    assign accept    = rd_req_o && rd_ready_i;
    assign tick      = (state_q == ST_RUN) && (tick_q == TICK_LAST);

    assign sample_out_o    = sample_q;
    assign sample_strobe_o = strobe_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = done_q;
    assign underrun_o      = underrun_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        base_d     = base_q;
        len_d      = len_q;
        issued_d   = issued_q;
        played_d   = played_q;
        loop_d     = loop_q;
        outst_d    = outst_q;
        tick_d     = '0;
        sample_d   = sample_q;
        strobe_d   = 1'b0;
        done_d     = 1'b0;
        underrun_d = underrun_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !stop_i && (length_i != '0)) begin
                    state_d    = ST_RUN;
                    base_d     = base_addr_i;
                    addr_d     = base_addr_i;
                    len_d      = length_i;
                    loop_d     = loop_en_i;
                    issued_d   = '0;
                    played_d   = '0;
                    underrun_d = 1'b0;
                end
            end
            ST_RUN: begin
                tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
                if (rd_valid_i) begin
                    fifo_push = 1'b1;
                    outst_d   = 1'b0;
                end
                if (accept) begin
                    outst_d = 1'b1;
                    if (loop_q && (issued_q + LEN_W'(1) == len_q)) begin
                        addr_d   = base_q;
                        issued_d = '0;
                    end else begin
                        addr_d   = addr_q + ADDR_W'(1);
                        issued_d = issued_q + LEN_W'(1);
                    end
                end
                if (tick) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        sample_d = fifo_dout;
                        strobe_d = 1'b1;
                        if (played_q + LEN_W'(1) == len_q) begin
                            played_d = '0;
                            if (!loop_q) begin
                                done_d  = 1'b1;
                                state_d = ST_DRAIN;
                            end
                        end else begin
                            played_d = played_q + LEN_W'(1);
                        end
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
                if (stop_i) begin
                    state_d = ST_DRAIN;
                end
                fifo_flush = (state_d == ST_DRAIN);
            end
            ST_DRAIN: begin
                // Returning data for the in-flight read is swallowed here.
                if (rd_valid_i) outst_d = 1'b0;
                if (!outst_q)   state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                outst_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            played_q   <= '0;
            loop_q     <= 1'b0;
            outst_q    <= 1'b0;
            tick_q     <= '0;
            sample_q   <= '0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            played_q   <= played_d;
            loop_q     <= loop_d;
            outst_q    <= outst_d;
            tick_q     <= tick_d;
            sample_q   <= sample_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_sample_player.sv
// Directed bench for sample_player with CLK_DIV=8, FIFO_DEPTH=4 and a 3-cycle-latency RAM model.
module tb_sample_player;
    import sample_player_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [25:0] base_addr = '0;
    logic [23:0] length = '0;
    logic        rd_req, rd_ready = 1'b1, rd_valid = 1'b0;
    logic [25:0] rd_addr;
    logic [15:0] rd_data = '0;
    logic [15:0] sample_out;
    logic        sample_strobe, busy, done, underrun;

    int checks = 0;
    int errors = 0;

    sample_player #(
        .CLK_DIV    (8),
        .FIFO_DEPTH (4),
        .ADDR_W     (26),
        .DATA_W     (16),
        .LEN_W      (24)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .stop_i          (stop),
        .loop_en_i       (loop_en),
        .base_addr_i     (base_addr),
        .length_i        (length),
        .rd_req_o        (rd_req),
        .rd_addr_o       (rd_addr),
        .rd_ready_i      (rd_ready),
        .rd_valid_i      (rd_valid),
        .rd_data_i       (rd_data),
        .sample_out_o    (sample_out),
        .sample_strobe_o (sample_strobe),
        .busy_o          (busy),
        .done_o          (done),
        .underrun_o      (underrun)
    );

    always #5 clk = ~clk;

    // RAM contents: 0x100..0x104 hold 1..5, everything else addr[15:0]^A5A5
    function automatic logic [15:0] mem_rd(input logic [25:0] a);
        if (a >= 26'h100 && a <= 26'h104) return 16'(a - 26'h0FF);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    int          cyc = 0;
    logic        acc_flag = 1'b0;
    logic [25:0] acc_addr = '0;
    logic [25:0] acc_log[$];
    int          lat = 0;
    logic [25:0] lat_addr = '0;
    int          valid_cnt = 0;
    logic [15:0] strb_vals[$];
    int          strb_cyc[$];
    int          done_cnt = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst_n && rd_req && rd_ready) begin
            acc_flag = 1'b1;
            acc_addr = rd_addr;
            acc_log.push_back(rd_addr);
        end else begin
            acc_flag = 1'b0;
        end
    end

    always @(negedge clk) begin
        rd_valid = 1'b0;
        if (lat != 0) begin
            lat--;
            if (lat == 0) begin
                rd_valid = 1'b1;
                rd_data  = mem_rd(lat_addr);
                valid_cnt++;
            end
        end
        if (acc_flag) begin
            lat      = 2;
            lat_addr = acc_addr;
            acc_flag = 1'b0;
        end
        if (sample_strobe) begin
            strb_vals.push_back(sample_out);
            strb_cyc.push_back(cyc);
        end
        if (done) done_cnt++;
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        acc_log.delete();
        strb_vals.delete();
        strb_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start(input logic [25:0] b, input logic [23:0] l, input logic lp, input logic with_stop);
        base_addr = b;
        length    = l;
        loop_en   = lp;
        start     = 1'b1;
        stop      = with_stop;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick_n(1);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick_n(2);
        checks++;
        if ({rd_req, sample_strobe, busy, done, underrun} !== 5'b0 || sample_out !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: req/strb/busy/done/und=%b sample=%h, required all 0",
                     {rd_req, sample_strobe, busy, done, underrun}, sample_out);
        end
        rst_n = 1'b1;
        tick_n(2);
        clear_logs();
        pulse_start(26'h100, 24'd5, 1'b0, 1'b0);
        tick_n(20);
        checks++;
        if (busy !== 1'b1 || strb_vals.size() != 2) begin
            errors++;
            $display("FAIL reset_prerun: busy=%b strobes=%0d, required 1 and 2", busy, strb_vals.size());
        end
        rst_n = 1'b0;
        tick_n(1);
        checks++;
        if ({rd_req, sample_strobe, busy, done, underrun} !== 5'b0 || sample_out !== 16'h0
            || dut.state_q !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_midrun: req/strb/busy/done/und=%b sample=%h state=%0d, required 0 and IDLE",
                     {rd_req, sample_strobe, busy, done, underrun}, sample_out, dut.state_q);
        end
        rst_n = 1'b1;
        tick_n(10);
        checks++;
        if (busy !== 1'b0 || dut.u_fifo.count_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_after: busy=%b fifo_count=%0d, required 0 and 0", busy, dut.u_fifo.count_o);
        end
    endtask

    task automatic test_play();
        int s_cyc;
        logic [25:0] max_addr;
        clear_logs();
        pulse_start(26'h100, 24'd5, 1'b0, 1'b0);
        s_cyc = cyc;
        wait_idle("play", 100);
        checks++;
        if (strb_vals.size() != 5) begin
            errors++;
            $display("FAIL play_count: got %0d strobes, required 5", strb_vals.size());
        end
        for (int i = 0; i < strb_vals.size(); i++) begin
            checks++;
            if (strb_vals[i] !== 16'(i + 1) || strb_cyc[i] != s_cyc + 8 * (i + 1)) begin
                errors++;
                $display("FAIL play_sample[%0d]: got %h at +%0d, required %h at +%0d",
                         i, strb_vals[i], strb_cyc[i] - s_cyc, 16'(i + 1), 8 * (i + 1));
            end
        end
        max_addr = '0;
        foreach (acc_log[i]) if (acc_log[i] > max_addr) max_addr = acc_log[i];
        checks++;
        if (done_cnt != 1 || acc_log.size() != 5 || max_addr !== 26'h104 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL play_misc: done=%0d reads=%0d max_addr=%h underrun=%b, required 1 5 104 0",
                     done_cnt, acc_log.size(), max_addr, underrun);
        end
    endtask

    task automatic test_loop();
        int n;
        clear_logs();
        pulse_start(26'h100, 24'd5, 1'b1, 1'b0);
        n = 0;
        while (strb_vals.size() < 12 && n < 200) begin
            tick_n(1);
            n++;
        end
        stop = 1'b1;
        tick_n(1);
        stop = 1'b0;
        wait_idle("loop", 30);
        checks++;
        if (strb_vals.size() != 12) begin
            errors++;
            $display("FAIL loop_count: got %0d strobes, required 12", strb_vals.size());
        end
        for (int i = 0; i < strb_vals.size(); i++) begin
            checks++;
            if (strb_vals[i] !== 16'((i % 5) + 1)) begin
                errors++;
                $display("FAIL loop_sample[%0d]: got %h, required %h", i, strb_vals[i], 16'((i % 5) + 1));
            end
        end
        checks++;
        if (done_cnt != 0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL loop_flags: done=%0d underrun=%b, required 0 0", done_cnt, underrun);
        end
        foreach (acc_log[i]) begin
            checks++;
            if (acc_log[i] < 26'h100 || acc_log[i] > 26'h104) begin
                errors++;
                $display("FAIL loop_addr[%0d]: got %h, required 100..104", i, acc_log[i]);
            end
        end
    endtask

    task automatic test_underrun();
        rst_n = 1'b0;
        tick_n(1);
        rst_n = 1'b1;
        tick_n(2);
        clear_logs();
        rd_ready = 1'b0;
        pulse_start(26'h100, 24'd5, 1'b0, 1'b0);
        tick_n(40);
        checks++;
        if (underrun !== 1'b1 || strb_vals.size() != 0 || sample_out !== 16'h0 || acc_log.size() != 0) begin
            errors++;
            $display("FAIL underrun_hold: underrun=%b strobes=%0d sample=%h reads=%0d, required 1 0 0000 0",
                     underrun, strb_vals.size(), sample_out, acc_log.size());
        end
        rd_ready = 1'b1;
        wait_idle("underrun", 200);
        checks++;
        if (strb_vals.size() != 5 || done_cnt != 1 || underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_resume: strobes=%0d done=%0d underrun=%b, required 5 1 1",
                     strb_vals.size(), done_cnt, underrun);
        end
        for (int i = 0; i < strb_vals.size(); i++) begin
            checks++;
            if (strb_vals[i] !== 16'(i + 1)) begin
                errors++;
                $display("FAIL underrun_sample[%0d]: got %h, required %h", i, strb_vals[i], 16'(i + 1));
            end
        end
    endtask

    task automatic test_edge();
        clear_logs();
        pulse_start(26'h100, 24'd0, 1'b0, 1'b0);
        tick_n(3);
        checks++;
        if (busy !== 1'b0 || rd_req !== 1'b0 || underrun !== 1'b1) begin
            errors++;
            $display("FAIL edge_len0: busy=%b rd_req=%b underrun=%b, required 0 0 1", busy, rd_req, underrun);
        end
        pulse_start(26'h100, 24'd5, 1'b0, 1'b1);
        tick_n(3);
        checks++;
        if (busy !== 1'b0 || acc_log.size() != 0) begin
            errors++;
            $display("FAIL edge_startstop: busy=%b reads=%0d, required 0 0", busy, acc_log.size());
        end
        pulse_start(26'h3FFFFFF, 24'd2, 1'b0, 1'b0);
        checks++;
        if (underrun !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL edge_start_clears: underrun=%b busy=%b, required 0 1", underrun, busy);
        end
        wait_idle("edge", 60);
        checks++;
        if (acc_log.size() != 2) begin
            errors++;
            $display("FAIL edge_reads: got %0d reads, required 2", acc_log.size());
        end else begin
            checks++;
            if (acc_log[0] !== 26'h3FFFFFF || acc_log[1] !== 26'h0) begin
                errors++;
                $display("FAIL edge_wrap: addrs %h %h, required 3ffffff 0000000", acc_log[0], acc_log[1]);
            end
        end
        checks++;
        if (strb_vals.size() != 2 || done_cnt != 1) begin
            errors++;
            $display("FAIL edge_play: strobes=%0d done=%0d, required 2 1", strb_vals.size(), done_cnt);
        end else begin
            checks++;
            if (strb_vals[0] !== 16'h5A5A || strb_vals[1] !== 16'hA5A5) begin
                errors++;
                $display("FAIL edge_data: got %h %h, required 5a5a a5a5", strb_vals[0], strb_vals[1]);
            end
        end
    endtask

    task automatic test_stop();
        int n;
        int v0;
        clear_logs();
        pulse_start(26'h100, 24'd5, 1'b0, 1'b0);
        n = 0;
        while (acc_log.size() < 2 && n < 40) begin
            tick_n(1);
            n++;
        end
        checks++;
        if (acc_log.size() != 2) begin
            errors++;
            $display("FAIL stop_accept: got %0d reads, required 2", acc_log.size());
        end
        v0 = valid_cnt;
        stop = 1'b1;
        tick_n(1);
        stop = 1'b0;
        checks++;
        if (dut.state_q !== ST_DRAIN || busy !== 1'b1 || rd_req !== 1'b0 || dut.u_fifo.count_o !== 3'd0) begin
            errors++;
            $display("FAIL stop_drain: state=%0d busy=%b rd_req=%b fifo_count=%0d, required DRAIN 1 0 0",
                     dut.state_q, busy, rd_req, dut.u_fifo.count_o);
        end
        tick_n(1);
        checks++;
        if (busy !== 1'b1 || valid_cnt != v0) begin
            errors++;
            $display("FAIL stop_wait: busy=%b returns=%0d, required 1 and %0d", busy, valid_cnt, v0);
        end
        wait_idle("stop", 20);
        tick_n(1);
        checks++;
        if (valid_cnt != v0 + 1 || dut.u_fifo.count_o !== 3'd0 || strb_vals.size() != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL stop_idle: returns=%0d fifo_count=%0d strobes=%0d done=%0d, required %0d 0 0 0",
                     valid_cnt, dut.u_fifo.count_o, strb_vals.size(), done_cnt, v0 + 1);
        end
    endtask

    initial begin
        test_reset();
        test_play();
        test_loop();
        test_underrun();
        test_edge();
        test_stop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
